// File: rtl/msrv_32_pc_sel_ctrl.sv
// PC select sequencing controller: boot delay, trap/MRET redirects, misaligned-target trap requests.
// Latency: an event pulse in RUN moves pc_src on the next edge; the PC loads on the first ready cycle after that.
// Backpressure: ahb_ready_in low holds pc_src and blocks handshakes; trap/MRET events arriving meanwhile stay pending.
module msrv_32_pc_sel_ctrl #(
  parameter int unsigned BOOT_WAIT = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ahb_ready_in,
  input  logic       trap_req_in,
  input  logic       mret_req_in,
  input  logic       misaligned_instr_in,
  output logic [1:0] pc_src_out,
  output logic       pc_we_out,
  output logic       flush_out,
  output logic       misaligned_trap_out,
  output logic       busy_out
);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_BOOT = 3'd1,
    S_RUN  = 3'd2,
    S_TRAP = 3'd3,
    S_RET  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(BOOT_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       pend_trap;
  logic       pend_mret;
  logic       pend_trap_nxt;
  logic       pend_mret_nxt;
  logic       take_trap;
  logic       take_mret;
  logic       any_event;

  // Event arbitration in RUN, pending-flag update and next-state selection
  always_comb begin
    take_trap     = (state == S_RUN) && (trap_req_in || pend_trap);
    take_mret     = (state == S_RUN) && !take_trap && (mret_req_in || pend_mret);
    // A completed redirect retires its pending flag; a new pulse that is not taken right away is kept
    pend_trap_nxt = (pend_trap && !((state == S_TRAP) && ahb_ready_in)) || (trap_req_in && !take_trap);
    pend_mret_nxt = (pend_mret && !((state == S_RET) && ahb_ready_in)) || (mret_req_in && !take_mret);
    state_nxt     = state;
    case (state)
      S_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = S_BOOT;
      S_RUN: begin
        if (take_trap)      state_nxt = S_TRAP;
        else if (take_mret) state_nxt = S_RET;
      end
      S_BOOT, S_TRAP, S_RET: begin
        // Chain straight into the next queued redirect so nothing is fetched from a stale PC
        if (ahb_ready_in) begin
          if (pend_trap_nxt)      state_nxt = S_TRAP;
          else if (pend_mret_nxt) state_nxt = S_RET;
          else                    state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // State, boot counter and pending flags; reset aborts any redirect and drops queued events
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_WAIT;
      wait_cnt  <= 4'd0;
      pend_trap <= 1'b0;
      pend_mret <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_trap <= pend_trap_nxt;
      pend_mret <= pend_mret_nxt;
      if (state == S_WAIT && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 4'd1;
      else                                          wait_cnt <= 4'd0;
    end
  end

  // Output decode: pc_src from registered state only, handshake strobes qualified by bus ready
  always_comb begin
    any_event           = trap_req_in || mret_req_in || pend_trap || pend_mret;
    pc_src_out          = 2'b00;
    pc_we_out           = 1'b0;
    flush_out           = 1'b0;
    misaligned_trap_out = 1'b0;
    busy_out            = 1'b1;
    case (state)
      S_WAIT: pc_src_out = 2'b00;
      S_BOOT: begin
        pc_src_out = 2'b00;
        pc_we_out  = ahb_ready_in;
      end
      S_RUN: begin
        pc_src_out          = 2'b11;
        busy_out            = 1'b0;
        // Misaligned target only matters when no redirect is about to replace the PC
        misaligned_trap_out = misaligned_instr_in && ahb_ready_in && !any_event;
        pc_we_out           = ahb_ready_in && !misaligned_trap_out;
      end
      S_TRAP: begin
        pc_src_out = 2'b10;
        pc_we_out  = ahb_ready_in;
        flush_out  = ahb_ready_in;
      end
      S_RET: begin
        pc_src_out = 2'b01;
        pc_we_out  = ahb_ready_in;
        flush_out  = ahb_ready_in;
      end
      default: pc_src_out = 2'b00;
    endcase
  end

endmodule
